apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 140 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single CPU-side transfer requests into APB
// SETUP/ACCESS sequences, with an optional wait-state timeout abort.
module apb_master_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        APB_PCLK,
  input  logic        APB_PRESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstb,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] paddr,
  output logic [31:0] pdata,
  output logic [3:0]  pstb,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        perr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        cpu_busy_next, cpu_done_next, cpu_err_next;
  logic [31:0] cpu_rdata_next, paddr_next, pdata_next;
  logic [3:0]  pstb_next;
  logic        pwrite_next, psel_next, penable_next;
  logic        timeout_hit;

  // Abort when the counter has already seen TIMEOUT-1 stalled cycles and this one stalls too.
  assign timeout_hit = (TIMEOUT != 16'd0) && (wait_cnt == (TIMEOUT - 16'd1));

  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state     <= IDLE;
      wait_cnt  <= 16'd0;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'd0;
      paddr     <= 32'd0;
      pdata     <= 32'd0;
      pstb      <= 4'd0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      cpu_busy  <= cpu_busy_next;
      cpu_done  <= cpu_done_next;
      cpu_err   <= cpu_err_next;
      cpu_rdata <= cpu_rdata_next;
      paddr     <= paddr_next;
      pdata     <= pdata_next;
      pstb      <= pstb_next;
      pwrite    <= pwrite_next;
      psel      <= psel_next;
      penable   <= penable_next;
    end
  end

  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    cpu_busy_next  = cpu_busy;
    cpu_done_next  = 1'b0;
    cpu_err_next   = cpu_err;
    cpu_rdata_next = cpu_rdata;
    paddr_next     = paddr;
    pdata_next     = pdata;
    pstb_next      = pstb;
    pwrite_next    = pwrite;
    psel_next      = psel;
    penable_next   = penable;

    case (state)
      IDLE: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        if (cpu_req) begin
          state_next    = SETUP;
          paddr_next    = cpu_addr;
          pdata_next    = cpu_wdata;
          pwrite_next   = cpu_we;
          pstb_next     = cpu_we ? cpu_wstb : 4'b0000;
          psel_next     = 1'b1;
          cpu_busy_next = 1'b1;
        end
      end

      SETUP: begin
        state_next    = ACCESS;
        penable_next  = 1'b1;
        wait_cnt_next = 16'd0;
      end

      ACCESS: begin
        // Completion wins over a timeout landing on the same edge.
        if (pready) begin
          state_next    = IDLE;
          psel_next     = 1'b0;
          penable_next  = 1'b0;
          cpu_busy_next = 1'b0;
          cpu_done_next = 1'b1;
          cpu_err_next  = perr;
          if (!pwrite) begin
            cpu_rdata_next = prdata;
          end
        end else if (timeout_hit) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          cpu_busy_next  = 1'b0;
          cpu_done_next  = 1'b1;
          cpu_err_next   = 1'b1;
          cpu_rdata_next = 32'd0;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end

      default: begin
        state_next    = IDLE;
        psel_next     = 1'b0;
        penable_next  = 1'b0;
        cpu_busy_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge, built with a short
// timeout so both completion and abort paths are reachable.
module tb_apb_master_bridge;

  localparam logic [15:0] TO = 16'd4;

  logic        APB_PCLK = 1'b0;
  logic        APB_PRESET;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstb;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, paddr, pdata, prdata;
  logic [3:0]  pstb;
  logic        pwrite, psel, penable, pready, perr;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          last_done = 0;
  int          first_done;
  logic [31:0] model_rdata;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .APB_PCLK  (APB_PCLK),
    .APB_PRESET(APB_PRESET),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstb  (cpu_wstb),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .paddr     (paddr),
    .pdata     (pdata),
    .pstb      (pstb),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .perr      (perr)
  );

  always #5 APB_PCLK = ~APB_PCLK;

  always @(posedge APB_PCLK) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge APB_PCLK);
    #1;
  endtask

  // One whole transfer: expected behaviour follows from the wait-state count
  // alone (complete after waits+1 ACCESS cycles, or abort after TO cycles).
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstb, input int waits, input logic [31:0] rd,
                                input logic err, input bit chain);
    bit          tmo;
    int          n;
    logic [3:0]  exp_stb;
    tmo     = (TO != 16'd0) && (waits >= int'(TO));
    n       = tmo ? int'(TO) : waits + 1;
    exp_stb = we ? wstb : 4'h0;

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstb = wstb;
    step();
    check_output("setup_psel", psel, 1);
    check_output("setup_penable", penable, 0);
    check_output("setup_busy", cpu_busy, 1);
    check_output("setup_paddr", paddr, addr);
    check_output("setup_pdata", pdata, wdata);
    check_output("setup_pwrite", pwrite, we);
    check_output("setup_pstb", pstb, exp_stb);

    // Inputs outside ACCESS, and CPU inputs once latched, must not matter.
    cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
    cpu_wdata = $urandom; cpu_wstb = 4'($urandom);
    pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;

    for (int i = 0; i < n; i++) begin
      step();
      check_output("access_psel", psel, 1);
      check_output("access_penable", penable, 1);
      check_output("access_done", cpu_done, 0);
      check_output("access_paddr", paddr, addr);
      check_output("access_pdata", pdata, wdata);
      check_output("access_pwrite", pwrite, we);
      check_output("access_pstb", pstb, exp_stb);
      pready = (!tmo && i == waits);
      perr   = pready ? err : 1'($urandom);
      prdata = pready ? rd : $urandom;
      cpu_req = 1'($urandom); cpu_addr = $urandom;
    end
    step();

    if (tmo) model_rdata = 32'd0;
    else if (!we) model_rdata = rd;
    check_output("done_pulse", cpu_done, 1);
    check_output("done_err", cpu_err, tmo ? 1'b1 : err);
    check_output("done_rdata", cpu_rdata, model_rdata);
    check_output("done_psel", psel, 0);
    check_output("done_penable", penable, 0);
    check_output("done_busy", cpu_busy, 0);
    check_output("done_paddr_hold", paddr, addr);
    last_done = cyc;
    pready = 1'($urandom); perr = 1'($urandom);
    cpu_req = 1'b0;
    if (!chain) begin
      step();
      check_output("idle_done", cpu_done, 0);
      check_output("idle_psel", psel, 0);
      check_output("idle_rdata", cpu_rdata, model_rdata);
    end
  endtask

  initial begin
    APB_PRESET = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstb = 0;
    prdata = 0; pready = 0; perr = 0;
    model_rdata = 32'd0;
    #1;
    check_output("rst_psel", psel, 0);
    check_output("rst_penable", penable, 0);
    check_output("rst_busy", cpu_busy, 0);
    check_output("rst_done", cpu_done, 0);
    check_output("rst_err", cpu_err, 0);
    check_output("rst_rdata", cpu_rdata, 0);
    check_output("rst_paddr", paddr, 0);
    check_output("rst_pdata", pdata, 0);
    check_output("rst_pstb", pstb, 0);
    check_output("rst_pwrite", pwrite, 0);
    step(); step();
    APB_PRESET = 1'b0;
    step();

    $display("[TB] directed transfers");
    apply_stimulus(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2000_0010, 32'h1234_5678, 4'hA, 3, 32'h0000_00A5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h3000_0000, 32'h0, 4'h3, 50, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h4000_0008, 32'h0, 4'hF, 1, 32'h5A5A_0F0F, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h5000_000C, 32'hCAFE_F00D, 4'h6, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("[TB] back-to-back transfers");
    apply_stimulus(1'b1, 32'h6000_0000, 32'h0000_1111, 4'h1, 0, 32'h0, 1'b0, 1'b1);
    first_done = last_done;
    apply_stimulus(1'b0, 32'h6000_0004, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0);
    check_output("b2b_period", 32'(last_done - first_done), 32'd3);

    $display("[TB] reset during ACCESS");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7000_0000; cpu_wdata = 32'h77; cpu_wstb = 4'hF;
    pready = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
    check_output("pre_rst_penable", penable, 1);
    #2 APB_PRESET = 1'b1;
    #1;
    check_output("midrst_psel", psel, 0);
    check_output("midrst_penable", penable, 0);
    check_output("midrst_busy", cpu_busy, 0);
    check_output("midrst_done", cpu_done, 0);
    check_output("midrst_rdata", cpu_rdata, 0);
    check_output("midrst_paddr", paddr, 0);
    model_rdata = 32'd0;
    step();
    APB_PRESET = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("post_rst_no_done", cpu_done, 0);
      check_output("post_rst_psel", psel, 0);
    end
    apply_stimulus(1'b0, 32'h7000_0004, 32'h0, 4'h0, 0, 32'h0000_0C0C, 1'b0, 1'b0);

    $display("[TB] randomized transfers");
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'($urandom), $urandom, $urandom, 4'($urandom),
                     int'($urandom_range(0, 6)), $urandom, 1'($urandom),
                     ($urandom_range(0, 3) == 0));
    end
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
